// File: rtl/sample_threshold_monitor_pkg.sv
// Shared definitions for the sample threshold monitor: FSM state encoding,
// event type codes and default configuration values.
package sample_threshold_monitor_pkg;

    typedef enum logic [1:0] {
        ST_BELOW   = 2'd0,
        ST_RISING  = 2'd1,
        ST_ABOVE   = 2'd2,
        ST_FALLING = 2'd3
    } state_e;

    localparam logic EVT_RISE = 1'b1;
    localparam logic EVT_FALL = 1'b0;

    localparam logic [7:0] THR_RESET_DEFAULT = 8'h80;
    localparam int         HOLD_CNT_DEFAULT  = 4;

endpackage

// File: rtl/sample_threshold_monitor_cmp.sv
// 8-bit unsigned greater-or-equal compare that produces the qualify bit
// for each incoming sample.
module sample_ge_cmp (
    input  logic [7:0] sample_i,
    input  logic [7:0] thr_i,
    output logic       ge_o
);

    assign ge_o = (sample_i >= thr_i);

endmodule

// File: rtl/sample_threshold_monitor.sv
// Debounced threshold monitor producing buffered rise/fall events over a
// valid/ready handshake. Defining STM_PEAK_EN adds episode peak tracking.
module sample_threshold_monitor
    import sample_threshold_monitor_pkg::*;
#(
    parameter int         HOLD_CNT  = HOLD_CNT_DEFAULT,
    parameter logic [7:0] THR_RESET = THR_RESET_DEFAULT
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       THR_LOAD,
    input  logic [7:0] THR_IN,
    input  logic       S_VALID,
    input  logic [7:0] S_DATA,
    output logic       S_READY,
    output logic       EVT_VALID,
    input  logic       EVT_READY,
    output logic       EVT_TYPE,
    output logic [7:0] EVT_SAMPLE,
    output logic [7:0] EVT_PEAK
);

    localparam logic [3:0] HOLD_LIM = HOLD_CNT[3:0];

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d, cnt_inc;
    logic [7:0] thr_q, thr_d;
    logic       evt_valid_q, evt_valid_d;
    logic       evt_type_q, evt_type_d;
    logic [7:0] evt_sample_q, evt_sample_d;
    logic       accept, q, fire, fire_type;

    sample_ge_cmp u_cmp (
        .sample_i (S_DATA),
        .thr_i    (thr_q),
        .ge_o     (q)
    );

    // Stall new samples only while an event is pending and not being taken.
    assign S_READY = !evt_valid_q || EVT_READY;
    assign accept  = S_VALID && S_READY;
    assign cnt_inc = cnt_q + 4'd1;
    assign thr_d   = THR_LOAD ? THR_IN : thr_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        fire      = 1'b0;
        fire_type = EVT_FALL;
        if (accept) begin
            case (state_q)
                // cnt is always 0 in BELOW/ABOVE, so cnt_inc doubles as the first count.
                ST_BELOW, ST_RISING: begin
                    if (q) begin
                        if (cnt_inc == HOLD_LIM) begin
                            state_d   = ST_ABOVE;
                            cnt_d     = 4'd0;
                            fire      = 1'b1;
                            fire_type = EVT_RISE;
                        end else begin
                            state_d = ST_RISING;
                            cnt_d   = cnt_inc;
                        end
                    end else begin
                        state_d = ST_BELOW;
                        cnt_d   = 4'd0;
                    end
                end
                ST_ABOVE, ST_FALLING: begin
                    if (!q) begin
                        if (cnt_inc == HOLD_LIM) begin
                            state_d   = ST_BELOW;
                            cnt_d     = 4'd0;
                            fire      = 1'b1;
                            fire_type = EVT_FALL;
                        end else begin
                            state_d = ST_FALLING;
                            cnt_d   = cnt_inc;
                        end
                    end else begin
                        state_d = ST_ABOVE;
                        cnt_d   = 4'd0;
                    end
                end
                default: begin
                    state_d = ST_BELOW;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    // A new event loading on the same edge as a consume takes priority.
    always_comb begin
        evt_valid_d  = evt_valid_q;
        evt_type_d   = evt_type_q;
        evt_sample_d = evt_sample_q;
        if (evt_valid_q && EVT_READY) begin
            evt_valid_d = 1'b0;
        end
        if (fire) begin
            evt_valid_d  = 1'b1;
            evt_type_d   = fire_type;
            evt_sample_d = S_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_BELOW;
            cnt_q        <= 4'd0;
            thr_q        <= THR_RESET;
            evt_valid_q  <= 1'b0;
            evt_type_q   <= 1'b0;
            evt_sample_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            thr_q        <= thr_d;
            evt_valid_q  <= evt_valid_d;
            evt_type_q   <= evt_type_d;
            evt_sample_q <= evt_sample_d;
        end
    end

    assign EVT_VALID  = evt_valid_q;
    assign EVT_TYPE   = evt_type_q;
    assign EVT_SAMPLE = evt_sample_q;

`ifdef STM_PEAK_EN
    logic [7:0] peak_q, peak_d;
    logic [7:0] evt_peak_q, evt_peak_d;

    always_comb begin
        peak_d     = peak_q;
        evt_peak_d = evt_peak_q;
        if (accept) begin
            if (state_q == ST_BELOW) begin
                if (q) begin
                    peak_d = S_DATA;
                end
            end else if (state_d == ST_BELOW) begin
                peak_d = 8'h00;
            end else if (q && (S_DATA > peak_q)) begin
                peak_d = S_DATA;
            end
        end
        // Fall events complete on a non-qualifying sample, so peak_q is final here.
        if (fire && (fire_type == EVT_FALL)) begin
            evt_peak_d = peak_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            peak_q     <= 8'h00;
            evt_peak_q <= 8'h00;
        end else begin
            peak_q     <= peak_d;
            evt_peak_q <= evt_peak_d;
        end
    end

    assign EVT_PEAK = evt_peak_q;
`else
    assign EVT_PEAK = 8'h00;
`endif

endmodule

// File: tb/tb_sample_threshold_monitor.sv
// Directed scoreboard bench: one monitor with HOLD_CNT=4 and one with HOLD_CNT=1.
module tb_sample_threshold_monitor;

    typedef struct packed {
        logic       typ;
        logic [7:0] samp;
        logic [7:0] peak;
        logic       chk_pk;
    } evt_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [1:0]      thr_load = '0;
    logic [1:0][7:0] thr_in = '0;
    logic [1:0]      s_valid = '0;
    logic [1:0][7:0] s_data = '0;
    logic [1:0]      s_ready;
    logic [1:0]      evt_valid;
    logic [1:0]      evt_ready = 2'b11;
    logic [1:0]      evt_type;
    logic [1:0][7:0] evt_sample;
    logic [1:0][7:0] evt_peak;

    int   checks = 0;
    int   errors = 0;
    evt_t exp_q0[$];
    evt_t exp_q1[$];

    always #5 clk = ~clk;

    sample_threshold_monitor #(.HOLD_CNT(4), .THR_RESET(8'h80)) dut4 (
        .CLK(clk), .RST(rst), .THR_LOAD(thr_load[0]), .THR_IN(thr_in[0]),
        .S_VALID(s_valid[0]), .S_DATA(s_data[0]), .S_READY(s_ready[0]),
        .EVT_VALID(evt_valid[0]), .EVT_READY(evt_ready[0]), .EVT_TYPE(evt_type[0]),
        .EVT_SAMPLE(evt_sample[0]), .EVT_PEAK(evt_peak[0])
    );

    sample_threshold_monitor #(.HOLD_CNT(1), .THR_RESET(8'h80)) dut1 (
        .CLK(clk), .RST(rst), .THR_LOAD(thr_load[1]), .THR_IN(thr_in[1]),
        .S_VALID(s_valid[1]), .S_DATA(s_data[1]), .S_READY(s_ready[1]),
        .EVT_VALID(evt_valid[1]), .EVT_READY(evt_ready[1]), .EVT_TYPE(evt_type[1]),
        .EVT_SAMPLE(evt_sample[1]), .EVT_PEAK(evt_peak[1])
    );

    function automatic logic [7:0] pk(input logic [7:0] p);
`ifdef STM_PEAK_EN
        return p;
`else
        return 8'h00;
`endif
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int d, input logic typ, input logic [7:0] samp,
                        input logic [7:0] peak, input logic chk_pk);
        evt_t e;
        e = '{typ: typ, samp: samp, peak: peak, chk_pk: chk_pk};
        if (d == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endtask

    task automatic rise(input int d, input logic [7:0] samp);
        push(d, 1'b1, samp, 8'h00, 1'b0);
    endtask

    task automatic fall(input int d, input logic [7:0] samp, input logic [7:0] peak);
        push(d, 1'b0, samp, pk(peak), 1'b1);
    endtask

    task automatic send(input int d, input logic [7:0] v);
        int n;
        n = 0;
        s_valid[d] = 1'b1;
        s_data[d]  = v;
        while (!s_ready[d] && n < 50) begin
            cyc();
            n++;
        end
        if (!s_ready[d]) begin
            checks++;
            errors++;
            $error("FAIL send_timeout: observed s_ready 0 expected 1 (dut %0d)", d);
        end
        cyc();
        s_valid[d] = 1'b0;
    endtask

    task automatic chk_reset_vals(input int d, input string tag);
        chk({tag, "_s_ready"},    {7'd0, s_ready[d]},   8'h01);
        chk({tag, "_evt_valid"},  {7'd0, evt_valid[d]}, 8'h00);
        chk({tag, "_evt_type"},   {7'd0, evt_type[d]},  8'h00);
        chk({tag, "_evt_sample"}, evt_sample[d],        8'h00);
        chk({tag, "_evt_peak"},   evt_peak[d],          8'h00);
    endtask

    task automatic score(input int d);
        evt_t e;
        if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
            checks++;
            errors++;
            $error("FAIL unexpected_evt: observed type %0d sample %h expected none (dut %0d)",
                   evt_type[d], evt_sample[d], d);
        end else begin
            e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk("evt_type", {7'd0, evt_type[d]}, {7'd0, e.typ});
            chk("evt_sample", evt_sample[d], e.samp);
            if (e.chk_pk) chk("evt_peak", evt_peak[d], e.peak);
            $display("dut%0d event type=%0d sample=%h peak=%h", d, evt_type[d],
                     evt_sample[d], evt_peak[d]);
        end
    endtask

    // Handshake completes on the following rising edge; inputs are stable here.
    always @(negedge clk) begin
        if (!rst) begin
            for (int d = 0; d < 2; d++) begin
                if (evt_valid[d] && evt_ready[d]) score(d);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset
        cyc(); cyc();
        chk_reset_vals(0, "rst");
        chk_reset_vals(1, "rst1");
        rst = 1'b0;
        cyc();
        chk("s_ready_after_rst", {7'd0, s_ready[0]}, 8'h01);

        // Broken run returns to BELOW: only the 4th of 0x85,0x91,0x92,0x93 rises
        send(0, 8'h80); send(0, 8'h90); send(0, 8'h7F); send(0, 8'h85);
        send(0, 8'h91); send(0, 8'h92);
        chk("no_evt_broken_run", {7'd0, evt_valid[0]}, 8'h00);
        rise(0, 8'h93);
        send(0, 8'h93);
        chk("rise_latency_b", {7'd0, evt_valid[0]}, 8'h01);
        cyc();
        chk("evt_consumed_b", {7'd0, evt_valid[0]}, 8'h00);

        // Backpressure on a fall event, stalled sample accepted on the consume edge
        evt_ready[0] = 1'b0;
        send(0, 8'h10); send(0, 8'h10); send(0, 8'h10);
        fall(0, 8'h10, 8'h93);
        send(0, 8'h10);
        chk("fall_pending", {7'd0, evt_valid[0]}, 8'h01);
        chk("s_ready_stall", {7'd0, s_ready[0]}, 8'h00);
        s_valid[0] = 1'b1;
        s_data[0]  = 8'h80;
        cyc(); cyc();
        chk("fall_held", {7'd0, evt_valid[0]}, 8'h01);
        chk("s_ready_held", {7'd0, s_ready[0]}, 8'h00);
        evt_ready[0] = 1'b1;
        #1;
        chk("s_ready_release", {7'd0, s_ready[0]}, 8'h01);
        cyc();
        s_valid[0] = 1'b0;
        chk("fall_consumed", {7'd0, evt_valid[0]}, 8'h00);
        send(0, 8'h90); send(0, 8'hFF);
        chk("no_evt_third", {7'd0, evt_valid[0]}, 8'h00);
        rise(0, 8'h81);
        send(0, 8'h81);
        chk("rise_latency_a", {7'd0, evt_valid[0]}, 8'h01);
        cyc();

        // Back to BELOW
        fall(0, 8'h10, 8'hFF);
        repeat (4) send(0, 8'h10);
        cyc();

        // Threshold load: the coincident sample sees the old threshold
        s_valid[0]  = 1'b1;
        s_data[0]   = 8'h30;
        thr_load[0] = 1'b1;
        thr_in[0]   = 8'h20;
        cyc();
        s_valid[0]  = 1'b0;
        thr_load[0] = 1'b0;
        send(0, 8'h30); send(0, 8'h30); send(0, 8'h30);
        chk("thr_old_used", {7'd0, evt_valid[0]}, 8'h00);
        rise(0, 8'h30);
        send(0, 8'h30);
        chk("thr_new_rise", {7'd0, evt_valid[0]}, 8'h01);
        cyc();
        fall(0, 8'h00, 8'h30);
        repeat (4) send(0, 8'h00);
        cyc();
        thr_load[0] = 1'b1;
        thr_in[0]   = 8'h80;
        cyc();
        thr_load[0] = 1'b0;

        // Idle gaps inside a run, then peak tracking
        rise(0, 8'h90);
        send(0, 8'h90); send(0, 8'h90);
        cyc(); cyc();
        send(0, 8'h90);
        chk("gap_no_evt", {7'd0, evt_valid[0]}, 8'h00);
        send(0, 8'h90);
        chk("gap_rise", {7'd0, evt_valid[0]}, 8'h01);
        cyc();
        send(0, 8'hC3); send(0, 8'hA0);
        fall(0, 8'h00, 8'hC3);
        repeat (4) send(0, 8'h00);
        cyc();

        // Mid-run reset discards the pending event and partial count
        evt_ready[0] = 1'b0;
        repeat (4) send(0, 8'h90);
        chk("pending_pre_rst", {7'd0, evt_valid[0]}, 8'h01);
        chk("pending_type", {7'd0, evt_type[0]}, 8'h01);
        rst = 1'b1;
        cyc();
        chk_reset_vals(0, "midrst");
        rst = 1'b0;
        evt_ready[0] = 1'b1;
        repeat (3) send(0, 8'h90);
        chk("cnt_cleared", {7'd0, evt_valid[0]}, 8'h00);
        rise(0, 8'h90);
        send(0, 8'h90);
        chk("rise_after_rst", {7'd0, evt_valid[0]}, 8'h01);
        cyc();

        // HOLD_CNT=1: rise and fall on consecutive accepts
        rise(1, 8'h90);
        fall(1, 8'h05, 8'h90);
        send(1, 8'h05);
        chk("h1_no_evt", {7'd0, evt_valid[1]}, 8'h00);
        send(1, 8'h90);
        chk("h1_rise_valid", {7'd0, evt_valid[1]}, 8'h01);
        chk("h1_rise_type", {7'd0, evt_type[1]}, 8'h01);
        send(1, 8'h05);
        chk("h1_fall_valid", {7'd0, evt_valid[1]}, 8'h01);
        chk("h1_fall_type", {7'd0, evt_type[1]}, 8'h00);
        cyc();
        chk("h1_consumed", {7'd0, evt_valid[1]}, 8'h00);

        cyc();
        chk("q0_drained", 8'(exp_q0.size()), 8'h00);
        chk("q1_drained", 8'(exp_q1.size()), 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
